// File: rtl/cache_sa_mp.sv
// Set-associative cache with independent zero-latency read ports, round-robin
// replacement, a registered eviction output under valid/ready, and 1-cycle flush.
module cache_sa_mp #(
  parameter int IDX_BITS     = 2,
  parameter int WAYS         = 2,
  parameter int NUM_RD_PORTS = 2,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_RD_PORTS-1:0]            rd_en_i,
  input  logic [NUM_RD_PORTS*ADDR_WIDTH-1:0] rd_addr_i,
  output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data_o,
  output logic [NUM_RD_PORTS-1:0]            rd_hit_o,
  input  logic                               wr_valid_i,
  output logic                               wr_ready_o,
  input  logic [ADDR_WIDTH-1:0]              wr_addr_i,
  input  logic [DATA_WIDTH-1:0]              wr_data_i,
  input  logic                               flush_i,
  output logic                               evict_valid_o,
  input  logic                               evict_ready_i,
  output logic [ADDR_WIDTH-1:0]              evict_addr_o,
  output logic [DATA_WIDTH-1:0]              evict_data_o
);

  localparam int NUM_SETS  = 2 ** IDX_BITS;
  localparam int TAG_WIDTH = ADDR_WIDTH - IDX_BITS;
  localparam int PTR_W     = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [WAYS-1:0]       valid    [NUM_SETS];
  logic [PTR_W-1:0]      rr_ptr   [NUM_SETS];
  logic [TAG_WIDTH-1:0]  tag_mem  [NUM_SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_mem [NUM_SETS][WAYS];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (WAYS == 1) return '0;
    return (p == PTR_W'(WAYS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [IDX_BITS-1:0]   set;
    logic [TAG_WIDTH-1:0]  tag;
    logic                  hit;
    logic [DATA_WIDTH-1:0] data;

    assign addr = rd_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
    assign set  = addr[IDX_BITS-1:0];
    assign tag  = addr[ADDR_WIDTH-1:IDX_BITS];

    always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int w = 0; w < WAYS; w++) begin
        if (rd_en_i[p] && valid[set][w] && (tag_mem[set][w] == tag)) begin
          hit  = 1'b1;
          data = data_mem[set][w];
        end
      end
    end

    assign rd_hit_o[p]                           = hit;
    assign rd_data_o[p*DATA_WIDTH +: DATA_WIDTH] = data;
  end

  logic [IDX_BITS-1:0]  wr_set;
  logic [TAG_WIDTH-1:0] wr_tag;
  logic                 wr_hit;
  logic                 has_inv;
  logic [PTR_W-1:0]     hit_way;
  logic [PTR_W-1:0]     inv_way;
  logic [PTR_W-1:0]     tgt_way;
  logic                 wr_fire;
  logic                 do_evict;

  assign wr_set = wr_addr_i[IDX_BITS-1:0];
  assign wr_tag = wr_addr_i[ADDR_WIDTH-1:IDX_BITS];

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    wr_hit  = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[wr_set][w]) begin
        has_inv = 1'b1;
        inv_way = PTR_W'(w);
      end
      if (valid[wr_set][w] && (tag_mem[wr_set][w] == wr_tag)) begin
        wr_hit  = 1'b1;
        hit_way = PTR_W'(w);
      end
    end
  end

  assign tgt_way    = wr_hit ? hit_way : (has_inv ? inv_way : rr_ptr[wr_set]);
  assign wr_ready_o = !flush_i && !(evict_valid_o && !evict_ready_i);
  assign wr_fire    = wr_valid_i && wr_ready_o;
  assign do_evict   = wr_fire && !wr_hit && !has_inv;

  // Control state: valid bits, replacement pointers, eviction register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid[s]  <= '0;
        rr_ptr[s] <= '0;
      end
      evict_valid_o <= 1'b0;
      evict_addr_o  <= '0;
      evict_data_o  <= '0;
    end else begin
      if (flush_i) begin
        for (int s = 0; s < NUM_SETS; s++) begin
          valid[s]  <= '0;
          rr_ptr[s] <= '0;
        end
      end else if (wr_fire) begin
        valid[wr_set][tgt_way] <= 1'b1;
        if (do_evict) rr_ptr[wr_set] <= next_ptr(rr_ptr[wr_set]);
      end

      if (do_evict) begin
        evict_valid_o <= 1'b1;
        evict_addr_o  <= {tag_mem[wr_set][tgt_way], wr_set};
        evict_data_o  <= data_mem[wr_set][tgt_way];
      end else if (evict_ready_i) begin
        evict_valid_o <= 1'b0;
      end
    end
  end

  // Tag/data arrays carry no reset; valid bits guard every use.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      tag_mem[wr_set][tgt_way]  <= wr_tag;
      data_mem[wr_set][tgt_way] <= wr_data_i;
    end
  end

endmodule

// File: tb/tb_cache_sa_mp.sv
// Directed bench for cache_sa_mp (IDX_BITS=2, WAYS=2, 2 read ports, 16-bit data, 8-bit address).
module tb_cache_sa_mp;

  logic        clk;
  logic        reset_n;
  logic [1:0]  rd_en_i;
  logic [15:0] rd_addr_i;
  logic [31:0] rd_data_o;
  logic [1:0]  rd_hit_o;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [7:0]  wr_addr_i;
  logic [15:0] wr_data_i;
  logic        flush_i;
  logic        evict_valid_o;
  logic        evict_ready_i;
  logic [7:0]  evict_addr_o;
  logic [15:0] evict_data_o;

  int checks = 0;
  int errors = 0;

  cache_sa_mp #(
    .IDX_BITS(2), .WAYS(2), .NUM_RD_PORTS(2), .DATA_WIDTH(16), .ADDR_WIDTH(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .rd_hit_o(rd_hit_o),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .flush_i(flush_i),
    .evict_valid_o(evict_valid_o), .evict_ready_i(evict_ready_i),
    .evict_addr_o(evict_addr_o), .evict_data_o(evict_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; one write occupies exactly one rising edge.
  task automatic do_write(input logic [7:0] a, input logic [15:0] d);
    wr_valid_i = 1'b1;
    wr_addr_i  = a;
    wr_data_i  = d;
    @(negedge clk);
    wr_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; rd_en_i = '0; rd_addr_i = '0; wr_valid_i = 1'b0;
    wr_addr_i = '0; wr_data_i = '0; flush_i = 1'b0; evict_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd_en_i = 2'b11; rd_addr_i = {8'h22, 8'h12};
    #1;
    checks++; if (rd_hit_o !== 2'b00) begin errors++; $display("FAIL reset_hit got %b want 00", rd_hit_o); end
    checks++; if (rd_data_o !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", rd_data_o); end
    checks++; if (evict_valid_o !== 1'b0) begin errors++; $display("FAIL reset_evict_valid got %b want 0", evict_valid_o); end
    checks++; if ({evict_addr_o, evict_data_o} !== 24'h0) begin errors++; $display("FAIL reset_evict_regs got %h/%h want 0/0", evict_addr_o, evict_data_o); end
    checks++; if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", wr_ready_o); end
    @(negedge clk);
  endtask

  task automatic test_fill;
    do_write(8'h12, 16'h00AB);
    do_write(8'h22, 16'h00CD);
    rd_en_i = 2'b11; rd_addr_i = {8'h22, 8'h12};
    #1;
    checks++; if (rd_hit_o !== 2'b11) begin errors++; $display("FAIL fill_hit got %b want 11", rd_hit_o); end
    checks++; if (rd_data_o !== {16'h00CD, 16'h00AB}) begin errors++; $display("FAIL fill_data got %h want 00cd00ab", rd_data_o); end
    checks++; if (evict_valid_o !== 1'b0) begin errors++; $display("FAIL fill_no_evict got %b want 0", evict_valid_o); end
    rd_en_i = 2'b01;
    #1;
    checks++; if ({rd_hit_o, rd_data_o} !== {2'b01, 16'h0000, 16'h00AB}) begin errors++; $display("FAIL fill_rd_en got %b/%h want 01/000000ab", rd_hit_o, rd_data_o); end
    rd_en_i = 2'b11;
  endtask

  task automatic test_evict;
    evict_ready_i = 1'b0;
    do_write(8'h32, 16'h0055);
    rd_addr_i = {8'h12, 8'h32};
    #1;
    checks++; if ({evict_valid_o, evict_addr_o, evict_data_o} !== {1'b1, 8'h12, 16'h00AB}) begin errors++; $display("FAIL evict_out got %b/%h/%h want 1/12/00ab", evict_valid_o, evict_addr_o, evict_data_o); end
    checks++; if ({rd_hit_o, rd_data_o} !== {2'b01, 16'h0000, 16'h0055}) begin errors++; $display("FAIL evict_read got %b/%h want 01/00000055", rd_hit_o, rd_data_o); end
    rd_addr_i = {8'h22, 8'h32};
    #1;
    checks++; if ({rd_hit_o, rd_data_o} !== {2'b11, 16'h00CD, 16'h0055}) begin errors++; $display("FAIL evict_keep_way1 got %b/%h want 11/00cd0055", rd_hit_o, rd_data_o); end
  endtask

  task automatic test_backpressure;
    #1;
    checks++; if (wr_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_low got %b want 0", wr_ready_o); end
    wr_valid_i = 1'b1; wr_addr_i = 8'h22; wr_data_i = 16'h0099;
    @(negedge clk);
    #1;
    checks++; if (rd_data_o[31:16] !== 16'h00CD) begin errors++; $display("FAIL bp_write_blocked got %h want 00cd", rd_data_o[31:16]); end
    checks++; if ({evict_valid_o, evict_addr_o, evict_data_o} !== {1'b1, 8'h12, 16'h00AB}) begin errors++; $display("FAIL bp_evict_stable got %b/%h/%h want 1/12/00ab", evict_valid_o, evict_addr_o, evict_data_o); end
    evict_ready_i = 1'b1;
    #1;
    checks++; if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_comb got %b want 1", wr_ready_o); end
    @(negedge clk);
    wr_valid_i = 1'b0;
    #1;
    checks++; if (evict_valid_o !== 1'b0) begin errors++; $display("FAIL bp_evict_drained got %b want 0", evict_valid_o); end
    checks++; if (rd_data_o[31:16] !== 16'h0099) begin errors++; $display("FAIL bp_hit_write got %h want 0099", rd_data_o[31:16]); end
  endtask

  task automatic test_rw_same;
    @(negedge clk);
    rd_addr_i = {8'h12, 8'h32};
    wr_valid_i = 1'b1; wr_addr_i = 8'h32; wr_data_i = 16'h0066;
    #1;
    checks++; if (rd_data_o[15:0] !== 16'h0055) begin errors++; $display("FAIL rw_old_data got %h want 0055", rd_data_o[15:0]); end
    @(negedge clk);
    wr_valid_i = 1'b0;
    #1;
    checks++; if (rd_data_o[15:0] !== 16'h0066) begin errors++; $display("FAIL rw_new_data got %h want 0066", rd_data_o[15:0]); end
    wr_valid_i = 1'b1; wr_addr_i = 8'h12; wr_data_i = 16'h0077;
    #1;
    checks++; if ({rd_hit_o[1], rd_data_o[31:16]} !== {1'b0, 16'h0000}) begin errors++; $display("FAIL rw_old_miss got %b/%h want 0/0000", rd_hit_o[1], rd_data_o[31:16]); end
    @(negedge clk);
    wr_valid_i = 1'b0;
    #1;
    checks++; if ({rd_hit_o[1], rd_data_o[31:16]} !== {1'b1, 16'h0077}) begin errors++; $display("FAIL rw_new_hit got %b/%h want 1/0077", rd_hit_o[1], rd_data_o[31:16]); end
    checks++; if ({evict_valid_o, evict_addr_o, evict_data_o} !== {1'b1, 8'h22, 16'h0099}) begin errors++; $display("FAIL rw_rr_victim got %b/%h/%h want 1/22/0099", evict_valid_o, evict_addr_o, evict_data_o); end
    @(negedge clk);
    #1;
    checks++; if (evict_valid_o !== 1'b0) begin errors++; $display("FAIL rw_evict_accepted got %b want 0", evict_valid_o); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    do_write(8'h02, 16'h0011);
    #1;
    checks++; if ({evict_valid_o, evict_addr_o, evict_data_o} !== {1'b1, 8'h32, 16'h0066}) begin errors++; $display("FAIL b2b_first got %b/%h/%h want 1/32/0066", evict_valid_o, evict_addr_o, evict_data_o); end
    checks++; if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", wr_ready_o); end
    do_write(8'h42, 16'h0022);
    #1;
    checks++; if ({evict_valid_o, evict_addr_o, evict_data_o} !== {1'b1, 8'h12, 16'h0077}) begin errors++; $display("FAIL b2b_second got %b/%h/%h want 1/12/0077", evict_valid_o, evict_addr_o, evict_data_o); end
    @(negedge clk);
    #1;
    checks++; if (evict_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", evict_valid_o); end
  endtask

  task automatic test_flush;
    @(negedge clk);
    do_write(8'h05, 16'h1234);
    evict_ready_i = 1'b0;
    do_write(8'h82, 16'hBEEF);
    flush_i = 1'b1;
    wr_valid_i = 1'b1; wr_addr_i = 8'h07; wr_data_i = 16'h7777;
    rd_addr_i = {8'h82, 8'h05};
    #1;
    checks++; if (wr_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", wr_ready_o); end
    checks++; if ({rd_hit_o, rd_data_o} !== {2'b11, 16'hBEEF, 16'h1234}) begin errors++; $display("FAIL flush_cycle_read got %b/%h want 11/beef1234", rd_hit_o, rd_data_o); end
    @(negedge clk);
    flush_i = 1'b0; wr_valid_i = 1'b0;
    #1;
    checks++; if ({rd_hit_o, rd_data_o} !== {2'b00, 32'h0}) begin errors++; $display("FAIL flush_miss got %b/%h want 00/00000000", rd_hit_o, rd_data_o); end
    checks++; if ({evict_valid_o, evict_addr_o, evict_data_o} !== {1'b1, 8'h02, 16'h0011}) begin errors++; $display("FAIL flush_evict_kept got %b/%h/%h want 1/02/0011", evict_valid_o, evict_addr_o, evict_data_o); end
    rd_addr_i = {8'h07, 8'h07};
    #1;
    checks++; if (rd_hit_o !== 2'b00) begin errors++; $display("FAIL flush_write_dropped got %b want 00", rd_hit_o); end
    evict_ready_i = 1'b1;
    @(negedge clk);
    do_write(8'h42, 16'hAAAA);
    do_write(8'h62, 16'hBBBB);
    rd_addr_i = {8'h62, 8'h42};
    #1;
    checks++; if ({rd_hit_o, rd_data_o} !== {2'b11, 16'hBBBB, 16'hAAAA}) begin errors++; $display("FAIL refill_read got %b/%h want 11/bbbbaaaa", rd_hit_o, rd_data_o); end
    do_write(8'h82, 16'hCCCC);
    #1;
    checks++; if ({evict_valid_o, evict_addr_o, evict_data_o} !== {1'b1, 8'h42, 16'hAAAA}) begin errors++; $display("FAIL refill_way0 got %b/%h/%h want 1/42/aaaa", evict_valid_o, evict_addr_o, evict_data_o); end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    evict_ready_i = 1'b0;
    do_write(8'hA2, 16'h0F0F);
    #1;
    checks++; if ({evict_valid_o, evict_addr_o, evict_data_o} !== {1'b1, 8'h62, 16'hBBBB}) begin errors++; $display("FAIL arst_pre_evict got %b/%h/%h want 1/62/bbbb", evict_valid_o, evict_addr_o, evict_data_o); end
    reset_n = 1'b0;
    rd_addr_i = {8'hA2, 8'h82};
    #1;
    checks++; if ({evict_valid_o, evict_addr_o, evict_data_o} !== {1'b0, 8'h00, 16'h0000}) begin errors++; $display("FAIL arst_evict_clear got %b/%h/%h want 0/00/0000", evict_valid_o, evict_addr_o, evict_data_o); end
    checks++; if (rd_hit_o !== 2'b00) begin errors++; $display("FAIL arst_valid_clear got %b want 00", rd_hit_o); end
    @(negedge clk);
    reset_n = 1'b1;
    evict_ready_i = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_evict();
    test_backpressure();
    test_rw_same();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
